// File: rtl/timer_ctrl_slave_if.sv
// ---------------------------------------------------------------------------
// timer_ctrl_slave_if
// Purpose : single-cycle register bus between a system master and the timer
//           control slave. One access per cycle when S_sel is high.
// Signals : S_sel   access strobe
//           S_wr    1 = write, 0 = read (only meaningful with S_sel)
//           S_addr  register address (3 bits)
//           S_din   write data (CNT_W bits)
//           S_dout  registered read data (CNT_W bits)
// Modports: master drives the request and samples S_dout,
//           slave samples the request and drives S_dout.
// ---------------------------------------------------------------------------
interface timer_ctrl_slave_if #(
    parameter int CNT_W = 8
) ();
    logic             S_sel;
    logic             S_wr;
    logic [2:0]       S_addr;
    logic [CNT_W-1:0] S_din;
    logic [CNT_W-1:0] S_dout;

    modport master (
        output S_sel,
        output S_wr,
        output S_addr,
        output S_din,
        input  S_dout
    );

    modport slave (
        input  S_sel,
        input  S_wr,
        input  S_addr,
        input  S_din,
        output S_dout
    );
endinterface

// File: rtl/timer_ctrl_slave.sv
// ---------------------------------------------------------------------------
// timer_ctrl_slave
// Purpose : bus-side register slave for an 8-bit timer counter. Holds the
//           counter's control inputs (CNT_EN, LOAD_VALUE, CNT_CON), raises a
//           maskable interrupt on INTERRUPT entry, acknowledges the counter
//           with a one-cycle int_clear, and counts expiries (saturating,
//           clear-on-read).
// Ports   : clk            system clock, rising edge
//           reset          synchronous active-high reset
//           bus            register bus (timer_ctrl_slave_if.slave)
//           counter_state  counter state: 00 IDLE, 01 COUNT, 10 INTERRUPT
//           COUNT_VALUE    live counter value
//           CNT_EN         counter enable
//           LOAD_VALUE     reload value
//           CNT_CON        1 = periodic reload, 0 = one-shot
//           int_clear      interrupt acknowledge to the counter
//           o_irq          interrupt request to the system
// Register map:
//           0 LOAD   RW   LOAD_VALUE
//           1 CTRL   RW   b0 CNT_EN, b1 CNT_CON, b2 INT_EN
//           2 STATUS      b0 irq_pending (W1C), b2:1 counter_state (RO)
//           3 COUNT  RO   COUNT_VALUE
//           4 EXPIRY RO   expiry count, clear-on-read
//           5-7           read 0, writes ignored
// ---------------------------------------------------------------------------
module timer_ctrl_slave #(
    parameter int CNT_W = 8,
    parameter int EXP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_ctrl_slave_if.slave    bus,
    input  logic [1:0]           counter_state,
    input  logic [CNT_W-1:0]     COUNT_VALUE,
    output logic                 CNT_EN,
    output logic [CNT_W-1:0]     LOAD_VALUE,
    output logic                 CNT_CON,
    output logic                 int_clear,
    output logic                 o_irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_INT   = 2'b10
    } cstate_e;

    localparam logic [2:0] A_LOAD   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_EXPIRY = 3'd4;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    logic [CNT_W-1:0] load_reg,        load_next;
    logic             cnt_en_reg,      cnt_en_next;
    logic             cnt_con_reg,     cnt_con_next;
    logic             int_en_reg,      int_en_next;
    logic             irq_pending_reg, irq_pending_next;
    logic             clr_pend_reg,    clr_pend_next;
    logic [EXP_W-1:0] expiry_reg,      expiry_next;
    cstate_e          prev_state_reg,  prev_state_next;
    logic [CNT_W-1:0] dout_reg,        dout_next;

    logic             wr_acc;
    logic             rd_acc;
    logic             in_int;
    logic             int_entry;
    logic             w1c;
    logic             ack_now;
    logic [CNT_W-1:0] exp_rd;
    logic [CNT_W-1:0] rd_data;

    assign wr_acc    = bus.S_sel &  bus.S_wr;
    assign rd_acc    = bus.S_sel & ~bus.S_wr;
    assign in_int    = (counter_state == ST_INT);
    // Edge-detect INTERRUPT so a counter parked there counts only once.
    assign int_entry = in_int && (prev_state_reg != ST_INT);
    assign w1c       = wr_acc && (bus.S_addr == A_STATUS) && bus.S_din[0];
    assign ack_now   = clr_pend_reg && in_int;

    // Expiry counter widened/truncated onto the bus width.
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_exp_rd
        if (gi < EXP_W) begin : g_bit
            assign exp_rd[gi] = expiry_reg[gi];
        end else begin : g_zero
            assign exp_rd[gi] = 1'b0;
        end
    end

    // Read mux shows register contents as they are in the access cycle.
    always_comb begin
        rd_data = '0;
        case (bus.S_addr)
            A_LOAD:   rd_data = load_reg;
            A_CTRL:   rd_data = {{(CNT_W-3){1'b0}}, int_en_reg, cnt_con_reg, cnt_en_reg};
            A_STATUS: rd_data = {{(CNT_W-3){1'b0}}, counter_state, irq_pending_reg};
            A_COUNT:  rd_data = COUNT_VALUE;
            A_EXPIRY: rd_data = exp_rd;
            default:  rd_data = '0;
        endcase
    end

    always_comb begin
        load_next        = load_reg;
        cnt_en_next      = cnt_en_reg;
        cnt_con_next     = cnt_con_reg;
        int_en_next      = int_en_reg;
        irq_pending_next = irq_pending_reg;
        clr_pend_next    = clr_pend_reg;
        expiry_next      = expiry_reg;
        prev_state_next  = cstate_e'(counter_state);
        dout_next        = rd_acc ? rd_data : '0;

        if (wr_acc && (bus.S_addr == A_LOAD)) begin
            load_next = bus.S_din;
        end

        // A CTRL write beats the one-shot auto-disable in the same cycle.
        if (wr_acc && (bus.S_addr == A_CTRL)) begin
            cnt_en_next  = bus.S_din[0];
            cnt_con_next = bus.S_din[1];
            int_en_next  = bus.S_din[2];
        end else if (!cnt_con_reg && (counter_state == ST_COUNT)) begin
            // One-shot: drop the enable once counting so the counter does
            // not restart from IDLE after it expires.
            cnt_en_next = 1'b0;
        end

        // A fresh expiry beats a simultaneous W1C so it is never lost.
        if (int_entry) begin
            irq_pending_next = 1'b1;
        end else if (w1c) begin
            irq_pending_next = 1'b0;
        end

        // Acknowledge request is only meaningful while the counter waits in
        // INTERRUPT; it is consumed by the single int_clear pulse.
        if (w1c && in_int) begin
            clr_pend_next = 1'b1;
        end else if (!in_int || ack_now) begin
            clr_pend_next = 1'b0;
        end

        if (rd_acc && (bus.S_addr == A_EXPIRY)) begin
            expiry_next = int_entry ? EXP_W'(1) : '0;
        end else if (int_entry && (expiry_reg != EXP_MAX)) begin
            expiry_next = expiry_reg + EXP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_reg        <= '0;
            cnt_en_reg      <= 1'b0;
            cnt_con_reg     <= 1'b0;
            int_en_reg      <= 1'b0;
            irq_pending_reg <= 1'b0;
            clr_pend_reg    <= 1'b0;
            expiry_reg      <= '0;
            prev_state_reg  <= ST_IDLE;
            dout_reg        <= '0;
        end else begin
            load_reg        <= load_next;
            cnt_en_reg      <= cnt_en_next;
            cnt_con_reg     <= cnt_con_next;
            int_en_reg      <= int_en_next;
            irq_pending_reg <= irq_pending_next;
            clr_pend_reg    <= clr_pend_next;
            expiry_reg      <= expiry_next;
            prev_state_reg  <= prev_state_next;
            dout_reg        <= dout_next;
        end
    end

    assign bus.S_dout = dout_reg;
    assign CNT_EN     = cnt_en_reg;
    assign LOAD_VALUE = load_reg;
    assign CNT_CON    = cnt_con_reg;
    assign o_irq      = irq_pending_reg & int_en_reg;
    // Suppressed while reset is held so a pending acknowledge never leaks out.
    assign int_clear  = ack_now && !reset;

endmodule

// File: tb/tb_timer_ctrl_slave.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl_slave
// Self-checking bench for timer_ctrl_slave: a table of register accesses,
// hand-written sequences against a small behavioural timer counter, and a
// randomized phase checked against a register-level reference model.
// ---------------------------------------------------------------------------
module tb_timer_ctrl_slave;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_ctrl_slave_if #(.CNT_W(CNT_W)) bus_if ();

    logic [1:0]       counter_state;
    logic [CNT_W-1:0] COUNT_VALUE;
    logic             CNT_EN;
    logic [CNT_W-1:0] LOAD_VALUE;
    logic             CNT_CON;
    logic             int_clear;
    logic             o_irq;

    // Counter side: either a behavioural timer or directly forced values.
    logic             cnt_model_on = 1'b0;
    logic [1:0]       forced_state = 2'b00;
    logic [7:0]       forced_value = 8'h00;
    logic [1:0]       cm_state = 2'b00;
    logic [7:0]       cm_value = 8'h00;
    int               ic_count = 0;

    assign counter_state = cnt_model_on ? cm_state : forced_state;
    assign COUNT_VALUE   = cnt_model_on ? cm_value : forced_value;

    timer_ctrl_slave #(.CNT_W(CNT_W), .EXP_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .counter_state (counter_state),
        .COUNT_VALUE   (COUNT_VALUE),
        .CNT_EN        (CNT_EN),
        .LOAD_VALUE    (LOAD_VALUE),
        .CNT_CON       (CNT_CON),
        .int_clear     (int_clear),
        .o_irq         (o_irq)
    );

    // Behavioural timer: IDLE -> COUNT on enable, count down LOAD..0,
    // INTERRUPT until acknowledged, then reload (periodic) or go idle.
    always @(posedge clk) begin
        if (int_clear) ic_count <= ic_count + 1;
        if (reset || !cnt_model_on) begin
            cm_state <= 2'b00;
            cm_value <= 8'h00;
        end else begin
            case (cm_state)
                2'b00: if (CNT_EN) begin cm_state <= 2'b01; cm_value <= LOAD_VALUE; end
                2'b01: if (cm_value == 8'h00) cm_state <= 2'b10;
                       else cm_value <= cm_value - 8'd1;
                2'b10: if (int_clear) begin
                           if (CNT_CON) begin cm_state <= 2'b01; cm_value <= LOAD_VALUE; end
                           else cm_state <= 2'b00;
                       end
                default: cm_state <= 2'b00;
            endcase
        end
    end

    // Reference model: register contents as the register map describes them.
    logic [7:0] m_load;
    bit         m_en, m_con, m_ie, m_pend, m_clr;
    int         m_exp;
    logic [1:0] m_prev;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 8'h00; m_en = 0; m_con = 0; m_ie = 0;
        m_pend = 0; m_clr = 0; m_exp = 0; m_prev = 2'b00;
    endtask

    function automatic logic [7:0] reg_view(input logic [2:0] a, input logic [1:0] st,
                                            input logic [7:0] cv);
        case (a)
            3'd0:    return m_load;
            3'd1:    return {5'd0, m_ie, m_con, m_en};
            3'd2:    return {5'd0, st, m_pend};
            3'd3:    return cv;
            3'd4:    return 8'(m_exp);
            default: return 8'h00;
        endcase
    endfunction

    // One bus cycle: drive, check combinational outputs before the edge,
    // advance the model, check registered outputs after the edge.
    task automatic step(input bit sel, input bit wr, input logic [2:0] addr,
                        input logic [7:0] din);
        logic [1:0] st;
        logic [7:0] cv;
        logic [7:0] exp_dout;
        bit w, r, w1c, entry, ic;
        bus_if.S_sel  = sel;
        bus_if.S_wr   = wr;
        bus_if.S_addr = addr;
        bus_if.S_din  = din;
        @(negedge clk);
        st = counter_state;
        cv = COUNT_VALUE;
        ic = m_clr && (st == 2'b10);
        chk("int_clear", 32'(int_clear), 32'(ic));
        chk("o_irq", 32'(o_irq), 32'(m_pend && m_ie));
        w     = sel && wr;
        r     = sel && !wr;
        w1c   = w && (addr == 3'd2) && din[0];
        entry = (st == 2'b10) && (m_prev != 2'b10);
        exp_dout = r ? reg_view(addr, st, cv) : 8'h00;
        if (w && addr == 3'd0) m_load = din;
        if (w && addr == 3'd1) begin
            m_en = din[0]; m_con = din[1]; m_ie = din[2];
        end else if (!m_con && st == 2'b01) begin
            m_en = 0;
        end
        if (entry) m_pend = 1;
        else if (w1c) m_pend = 0;
        if (w1c && st == 2'b10) m_clr = 1;
        else if (st != 2'b10 || ic) m_clr = 0;
        if (r && addr == 3'd4) m_exp = entry ? 1 : 0;
        else if (entry) m_exp = (m_exp + 1 > 255) ? 255 : m_exp + 1;
        m_prev = st;
        @(posedge clk);
        #1;
        chk("S_dout", 32'(bus_if.S_dout), 32'(exp_dout));
        chk("CNT_EN", 32'(CNT_EN), 32'(m_en));
        chk("LOAD_VALUE", 32'(LOAD_VALUE), 32'(m_load));
        chk("CNT_CON", 32'(CNT_CON), 32'(m_con));
        if (sel)
            $display("txn %s addr=%0d din=%02h dout=%02h state=%0d", wr ? "WR" : "RD",
                     addr, din, bus_if.S_dout, st);
    endtask

    // Reset held for n cycles with every input toggling.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus_if.S_sel  = 1'($urandom);
            bus_if.S_wr   = 1'($urandom);
            bus_if.S_addr = 3'($urandom);
            bus_if.S_din  = 8'($urandom);
            forced_state  = 2'($urandom_range(0, 2));
            forced_value  = 8'($urandom);
            @(negedge clk);
            chk("rst_int_clear_pre", 32'(int_clear), 32'd0);
            @(posedge clk);
            #1;
            chk("rst_o_irq", 32'(o_irq), 32'd0);
            chk("rst_int_clear", 32'(int_clear), 32'd0);
            chk("rst_cnt_en", 32'(CNT_EN), 32'd0);
            chk("rst_load", 32'(LOAD_VALUE), 32'd0);
            chk("rst_cnt_con", 32'(CNT_CON), 32'd0);
            chk("rst_dout", 32'(bus_if.S_dout), 32'd0);
        end
        $display("txn RESET cycles=%0d", n);
        reset = 1'b0;
        bus_if.S_sel = 1'b0; bus_if.S_wr = 1'b0; bus_if.S_addr = 3'd0; bus_if.S_din = 8'h00;
        forced_state = 2'b00;
        model_reset();
    endtask

    task automatic wait_state(input logic [1:0] target, input int max, input string name);
        int n = 0;
        while (counter_state != target && n < max) begin
            step(0, 0, 3'd0, 8'h00);
            n++;
        end
        chk(name, 32'(counter_state), 32'(target));
    endtask

    // Let one expiry happen, then acknowledge it.
    task automatic service_one();
        wait_state(2'b10, 40, "svc_wait_int");
        step(0, 0, 3'd0, 8'h00);
        step(1, 1, 3'd2, 8'h01);
        step(0, 0, 3'd0, 8'h00);
    endtask

    typedef struct {
        bit         sel;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ic0;
        // Access table, run with the counter forced to COUNT and value 0x3C.
        vecs[0]  = '{1, 0, 3'd0, 8'h00, 8'h00};
        vecs[1]  = '{1, 0, 3'd1, 8'h00, 8'h00};
        vecs[2]  = '{1, 0, 3'd2, 8'h00, 8'h02};
        vecs[3]  = '{1, 0, 3'd3, 8'h00, 8'h3C};
        vecs[4]  = '{1, 0, 3'd4, 8'h00, 8'h00};
        vecs[5]  = '{1, 0, 3'd5, 8'h00, 8'h00};
        vecs[6]  = '{1, 0, 3'd6, 8'h00, 8'h00};
        vecs[7]  = '{1, 0, 3'd7, 8'h00, 8'h00};
        vecs[8]  = '{1, 1, 3'd0, 8'hA5, 8'h00};
        vecs[9]  = '{1, 0, 3'd0, 8'h00, 8'hA5};
        vecs[10] = '{1, 1, 3'd1, 8'hFE, 8'h00};
        vecs[11] = '{1, 0, 3'd1, 8'h00, 8'h06};
        vecs[12] = '{1, 1, 3'd5, 8'hFF, 8'h00};
        vecs[13] = '{1, 0, 3'd5, 8'h00, 8'h00};
        vecs[14] = '{1, 1, 3'd3, 8'h77, 8'h00};
        vecs[15] = '{1, 0, 3'd3, 8'h00, 8'h3C};
        vecs[16] = '{0, 0, 3'd2, 8'h00, 8'h00};

        bus_if.S_sel = 1'b0; bus_if.S_wr = 1'b0; bus_if.S_addr = 3'd0; bus_if.S_din = 8'h00;
        model_reset();
        do_reset(4);

        forced_state = 2'b01;
        forced_value = 8'h3C;
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].din);
            chk($sformatf("vec%0d_dout", i), 32'(bus_if.S_dout), 32'(vecs[i].dout));
        end

        // One-shot run through the behavioural timer.
        do_reset(2);
        cnt_model_on = 1'b1;
        step(1, 1, 3'd0, 8'd5);
        step(1, 1, 3'd1, 8'h05);
        chk("A_cnt_en_set", 32'(CNT_EN), 32'd1);
        wait_state(2'b01, 10, "A_wait_count");
        chk("A_cnt_en_in_count", 32'(CNT_EN), 32'd1);
        step(0, 0, 3'd0, 8'h00);
        chk("A_auto_clear", 32'(CNT_EN), 32'd0);
        wait_state(2'b10, 20, "A_wait_int");
        step(0, 0, 3'd0, 8'h00);
        chk("A_irq_after_entry", 32'(o_irq), 32'd1);
        step(1, 0, 3'd2, 8'h00);
        chk("A_status", 32'(bus_if.S_dout), 32'h05);
        ic0 = ic_count;
        step(1, 1, 3'd2, 8'h01);
        chk("A_int_clear_high", 32'(int_clear), 32'd1);
        chk("A_irq_cleared", 32'(o_irq), 32'd0);
        step(0, 0, 3'd0, 8'h00);
        chk("A_int_clear_low", 32'(int_clear), 32'd0);
        chk("A_counter_idle", 32'(counter_state), 32'd0);
        step(0, 0, 3'd0, 8'h00);
        chk("A_one_pulse", 32'(ic_count - ic0), 32'd1);

        // Periodic run: expiry counting, clear-on-read and saturation.
        do_reset(2);
        cnt_model_on = 1'b1;
        step(1, 1, 3'd0, 8'd3);
        step(1, 1, 3'd1, 8'h07);
        for (int k = 0; k < 3; k++) service_one();
        step(1, 0, 3'd4, 8'h00);
        chk("B_expiry_3", 32'(bus_if.S_dout), 32'd3);
        step(1, 0, 3'd4, 8'h00);
        chk("B_expiry_cleared", 32'(bus_if.S_dout), 32'd0);
        for (int k = 0; k < 300; k++) service_one();
        step(1, 0, 3'd4, 8'h00);
        chk("B_expiry_sat", 32'(bus_if.S_dout), 32'd255);

        // Entry and W1C on the same edge, then reset with clr_pend set.
        do_reset(2);
        cnt_model_on = 1'b0;
        step(1, 1, 3'd1, 8'h04);
        forced_state = 2'b10;
        step(0, 0, 3'd0, 8'h00);
        chk("C_irq_first", 32'(o_irq), 32'd1);
        forced_state = 2'b00;
        step(0, 0, 3'd0, 8'h00);
        forced_state = 2'b10;
        step(1, 1, 3'd2, 8'h01);
        chk("C_pending_kept", 32'(o_irq), 32'd1);
        reset = 1'b1;
        bus_if.S_sel = 1'b0;
        ic0 = ic_count;
        @(negedge clk);
        chk("D_int_clear_in_reset", 32'(int_clear), 32'd0);
        @(posedge clk);
        #1;
        chk("D_irq_after_reset", 32'(o_irq), 32'd0);
        chk("D_int_clear_after_reset", 32'(int_clear), 32'd0);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 3'd0, 8'h00);
        chk("D_no_pulse", 32'(ic_count - ic0), 32'd0);

        // Randomized accesses and counter states against the model.
        do_reset(2);
        cnt_model_on = 1'b0;
        for (int k = 0; k < 600; k++) begin
            bit         s, w;
            logic [2:0] a;
            logic [7:0] d;
            forced_state = 2'($urandom_range(0, 2));
            forced_value = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            w = 1'($urandom);
            a = 3'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset(1);
            else step(s, w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
